// File: rtl/video_mnist_pkg.sv
// Shared constants and types for the MNIST classifier argmax stage.
package video_mnist_pkg;

  localparam int unsigned NUM_CLASS    = 10;
  localparam int unsigned CLASS_UNIT   = 7;
  localparam int unsigned COUNT_WIDTH  = 3;
  localparam int unsigned CLASS_WIDTH  = 4;
  localparam int unsigned CLASS_REJECT = NUM_CLASS;

  typedef logic [CLASS_WIDTH-1:0] class_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/video_mnist_popcount.sv
// Combinational population count of one class's binary voters.
module video_mnist_popcount
  import video_mnist_pkg::*;
#(
  parameter int unsigned UNIT_W = CLASS_UNIT,
  parameter int unsigned CNT_W  = COUNT_WIDTH
) (
  input  logic [UNIT_W-1:0] i_bits,
  output logic [CNT_W-1:0]  o_count
);

  // Sum of set voter bits; CNT_W is sized so the sum cannot wrap.
  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < UNIT_W; i++) begin
      o_count = o_count + CNT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/video_mnist_cnn_argmax.sv
// Per-pixel argmax over MNIST class voter popcounts, 2-stage stallable
// AXI4-Stream pipeline. Optional reject threshold enabled by defining
// VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN (adds port param_threshold).
module video_mnist_cnn_argmax #(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned NUM_CLASS     = video_mnist_pkg::NUM_CLASS,
  parameter int unsigned CLASS_UNIT    = video_mnist_pkg::CLASS_UNIT,
  parameter int unsigned S_TDATA_WIDTH = NUM_CLASS * CLASS_UNIT,
  parameter int unsigned COUNT_WIDTH   = video_mnist_pkg::COUNT_WIDTH,
  parameter int unsigned CLASS_WIDTH   = video_mnist_pkg::CLASS_WIDTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
`ifdef VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN
  input  logic [COUNT_WIDTH-1:0]   param_threshold,
`endif
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]   m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]   m_axi4s_tcount,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  logic                   w_cke;
  logic [COUNT_WIDTH-1:0] w_cnt [NUM_CLASS];

  logic [COUNT_WIDTH-1:0] r_st1_cnt [NUM_CLASS];
  logic [TUSER_WIDTH-1:0] r_st1_user;
  logic                   r_st1_last;
  logic                   r_st1_valid;
`ifdef VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN
  logic [COUNT_WIDTH-1:0] r_st1_thr;
`endif

  logic [COUNT_WIDTH-1:0] w_best_cnt;
  logic [CLASS_WIDTH-1:0] w_best_idx;
  logic [CLASS_WIDTH-1:0] w_class;

  logic [TUSER_WIDTH-1:0] r_m_user;
  logic                   r_m_last;
  logic [CLASS_WIDTH-1:0] r_m_class;
  logic [COUNT_WIDTH-1:0] r_m_count;
  logic                   r_m_valid;

  // Whole pipeline advances unless the output holds an unaccepted beat.
  always_comb begin
    w_cke = !r_m_valid || m_axi4s_tready;
  end

  assign s_axi4s_tready = w_cke;

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_pc
    video_mnist_popcount #(
      .UNIT_W (CLASS_UNIT),
      .CNT_W  (COUNT_WIDTH)
    ) u_popcount (
      .i_bits  (s_axi4s_tdata[c*CLASS_UNIT +: CLASS_UNIT]),
      .o_count (w_cnt[c])
    );
  end

  // Stage 1: register per-class counts with framing and valid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned c = 0; c < NUM_CLASS; c++) begin
        r_st1_cnt[c] <= '0;
      end
      r_st1_user  <= '0;
      r_st1_last  <= 1'b0;
      r_st1_valid <= 1'b0;
`ifdef VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN
      r_st1_thr   <= '0;
`endif
    end else if (w_cke) begin
      for (int unsigned c = 0; c < NUM_CLASS; c++) begin
        r_st1_cnt[c] <= w_cnt[c];
      end
      r_st1_user  <= s_axi4s_tuser;
      r_st1_last  <= s_axi4s_tlast;
      r_st1_valid <= s_axi4s_tvalid;
`ifdef VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN
      r_st1_thr   <= param_threshold;
`endif
    end
  end

  // Argmax: strict greater-than scan upward, so the lowest index wins ties.
  always_comb begin
    w_best_cnt = r_st1_cnt[0];
    w_best_idx = '0;
    for (int unsigned i = 1; i < NUM_CLASS; i++) begin
      if (r_st1_cnt[i] > w_best_cnt) begin
        w_best_cnt = r_st1_cnt[i];
        w_best_idx = CLASS_WIDTH'(i);
      end
    end
  end

  // Winning class, replaced by the reject code when below threshold.
  always_comb begin
    w_class = w_best_idx;
`ifdef VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN
    if (w_best_cnt < r_st1_thr) begin
      w_class = CLASS_WIDTH'(NUM_CLASS);
    end
`endif
  end

  // Stage 2: output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_user  <= '0;
      r_m_last  <= 1'b0;
      r_m_class <= '0;
      r_m_count <= '0;
      r_m_valid <= 1'b0;
    end else if (w_cke) begin
      r_m_user  <= r_st1_user;
      r_m_last  <= r_st1_last;
      r_m_class <= w_class;
      r_m_count <= w_best_cnt;
      r_m_valid <= r_st1_valid;
    end
  end

  assign m_axi4s_tuser  = r_m_user;
  assign m_axi4s_tlast  = r_m_last;
  assign m_axi4s_tclass = r_m_class;
  assign m_axi4s_tcount = r_m_count;
  assign m_axi4s_tvalid = r_m_valid;

endmodule

// File: tb/tb_video_mnist_cnn_argmax.sv
// Scoreboard bench for video_mnist_cnn_argmax. Define
// VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN to also exercise the reject threshold.
module tb_video_mnist_cnn_argmax;
  import video_mnist_pkg::*;

  typedef struct packed {
    logic [3:0] cls;
    logic [2:0] cnt;
    logic       user;
    logic       last;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [0:0]  s_tuser = '0;
  logic        s_tlast = 1'b0;
  logic [69:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [0:0]  m_tuser;
  logic        m_tlast;
  logic [3:0]  m_tclass;
  logic [2:0]  m_tcount;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [2:0]  tb_thr = '0;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   out_beats = 0;
  exp_t q[$];

  bit       bp_en = 0;
  int       bp_idx = 0;
  bit       bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  bit       prev_stall = 0;
  exp_t     held;
  logic     held_valid;

  video_mnist_cnn_argmax dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
`ifdef VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN
    .param_threshold(tb_thr),
`endif
    .s_axi4s_tuser  (s_tuser),
    .s_axi4s_tlast  (s_tlast),
    .s_axi4s_tdata  (s_tdata),
    .s_axi4s_tvalid (s_tvalid),
    .s_axi4s_tready (s_tready),
    .m_axi4s_tuser  (m_tuser),
    .m_axi4s_tlast  (m_tlast),
    .m_axi4s_tclass (m_tclass),
    .m_axi4s_tcount (m_tcount),
    .m_axi4s_tvalid (m_tvalid),
    .m_axi4s_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [69:0] mk(input int c, input logic [6:0] b);
    logic [69:0] d;
    d = '0;
    d[c*7 +: 7] = b;
    return d;
  endfunction

  // Reference: popcount each class, strict > scan from class 0.
  function automatic exp_t model(input logic [69:0] d, input logic u, input logic l, input int thr);
    exp_t e;
    int   best, bc, n;
    best = 0;
    bc   = $countones(d[6:0]);
    for (int c = 1; c < 10; c++) begin
      n = $countones(d[c*7 +: 7]);
      if (n > bc) begin
        bc   = n;
        best = c;
      end
    end
    if (bc < thr) best = CLASS_REJECT;
    e.cls  = 4'(best);
    e.cnt  = 3'(bc);
    e.user = u;
    e.last = l;
    return e;
  endfunction

  task automatic step_ready();
    if (bp_en) begin
      m_tready = bp_pat[bp_idx];
      bp_idx   = (bp_idx + 1) % 4;
    end
  endtask

  // Present one beat until accepted; expectation queued at the accepting edge.
  task automatic send(input logic [69:0] d, input logic u, input logic l, input exp_t e);
    bit done;
    int guard;
    done  = 0;
    guard = 0;
    while (!done) begin
      @(posedge aclk); #1;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      step_ready();
      #1;
      if (s_tready) begin
        q.push_back(e);
        done = 1;
      end
      guard++;
      if (guard > 200) begin
        $display("FAIL send_timeout: got 0 expected 1");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "input never accepted");
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
      s_tvalid = 1'b0;
      s_tuser  = '0;
      s_tlast  = 1'b0;
      step_ready();
    end
  endtask

  function automatic exp_t ex(input int c, input int n, input logic u, input logic l);
    exp_t e;
    e.cls = 4'(c); e.cnt = 3'(n); e.user = u; e.last = l;
    return e;
  endfunction

  // Monitor: compare each output handshake with the scoreboard head.
  always @(negedge aclk) begin
    exp_t act, e;
    if (aresetn) begin
      act = '{m_tclass, m_tcount, m_tuser[0], m_tlast};
      chk("tready_rel", int'(s_tready), int'(!(m_tvalid && !m_tready)));
      if (prev_stall) begin
        chk("stall_hold", int'({m_tvalid, act}), int'({held_valid, held}));
      end
      if (m_tvalid && m_tready) begin
        out_beats++;
        if (q.size() == 0) begin
          chk("unexpected_beat", int'(act), -1);
        end else begin
          e = q.pop_front();
          chk("beat", int'(act), int'(e));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      held       = act;
      held_valid = m_tvalid;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    logic [69:0] d;
    int          beats0;

    // Reset state
    #23;
    chk("rst_valid", int'(m_tvalid), 0);
    chk("rst_class", int'(m_tclass), 0);
    chk("rst_count", int'(m_tcount), 0);
    chk("rst_user",  int'(m_tuser),  0);
    chk("rst_last",  int'(m_tlast),  0);
    aresetn = 1'b1;
    idle(2);

    // Single beat: class 3 full, latency 2, valid for one cycle
    send(mk(3, 7'b1111111), 1'b0, 1'b0, ex(3, 7, 1'b0, 1'b0));
    idle(1);
    @(negedge aclk); chk("lat_c1", int'(m_tvalid), 0);
    @(negedge aclk); chk("lat_c2", int'(m_tvalid), 1);
    chk("single_class", int'(m_tclass), 3);
    chk("single_count", int'(m_tcount), 7);
    @(negedge aclk); chk("lat_c3", int'(m_tvalid), 0);

    // Tie between class 2 and 5, lower index wins; all-zero
    d = mk(2, 7'b0001111) | mk(5, 7'b1010101) | mk(0, 7'b0000111) | mk(9, 7'b0000011);
    send(d, 1'b0, 1'b0, ex(2, 4, 1'b0, 1'b0));
    send('0, 1'b0, 1'b0, ex(0, 0, 1'b0, 1'b0));
    d = mk(8, 7'b0000001) | mk(9, 7'b0000011);
    send(d, 1'b1, 1'b1, ex(9, 2, 1'b1, 1'b1));
    idle(4);

    // Backpressure with ready pattern 1,0,0,1 and a bubble in the middle
    bp_en  = 1;
    bp_idx = 0;
    for (int i = 0; i < 8; i++) begin
      d = 70'({$urandom(), $urandom(), $urandom()});
      send(d, 1'(i == 0), 1'(i == 7), model(d, 1'(i == 0), 1'(i == 7), 0));
      if (i == 3) idle(1);
    end
    idle(12);
    bp_en    = 0;
    m_tready = 1'b1;
    idle(3);

    // 28x28 frame: tuser on first beat, tlast every 28th
    beats0 = out_beats;
    for (int i = 0; i < 784; i++) begin
      d = mk(i % 10, 7'(7'h7F >> (i % 7))) | mk((i + 3) % 10, 7'(i % 128));
      send(d, 1'(i == 0), 1'(i % 28 == 27), model(d, 1'(i == 0), 1'(i % 28 == 27), 0));
    end
    idle(4);
    chk("frame_beats", out_beats - beats0, 784);

`ifdef VIDEO_MNIST_CNN_ARGMAX_THRESHOLD_EN
    tb_thr = 3'd5;
    send(mk(7, 7'b1111000) | mk(0, 7'b0000011), 1'b0, 1'b0, ex(CLASS_REJECT, 4, 1'b0, 1'b0));
    send(mk(1, 7'b0111111) | mk(4, 7'b0011111), 1'b0, 1'b0, ex(1, 6, 1'b0, 1'b0));
    idle(4);
    tb_thr = '0;
    idle(2);
`endif

    // Reset with two beats in flight
    beats0 = out_beats;
    send(mk(4, 7'b1111111), 1'b0, 1'b0, ex(4, 7, 1'b0, 1'b0));
    send(mk(6, 7'b1111111), 1'b0, 1'b0, ex(6, 7, 1'b0, 1'b0));
    @(posedge aclk); #2;
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    #1;
    chk("rst_async_valid", int'(m_tvalid), 0);
    q.delete();
    repeat (2) @(posedge aclk);
    #3;
    aresetn = 1'b1;
    idle(8);
    chk("rst_no_stale", out_beats - beats0, 0);

    // Drain
    m_tready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
